// File: rtl/vram_text_writer_if.sv
// ---------------------------------------------------------------------------
// vram_text_writer_if
// Bundles the byte-stream input handshake, the VRAM port-A write bus and the
// status outputs of the text VRAM writer.
//   master : byte producer / VRAM observer (drives in_valid, in_data)
//   slave  : the writer engine (drives in_ready, v_ada, v_din, v_cea, busy,
//            cursor_col, cursor_row)
// ---------------------------------------------------------------------------
interface vram_text_writer_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [9:0] v_ada;
    logic [7:0] v_din;
    logic       v_cea;
    logic       busy;
    logic [5:0] cursor_col;
    logic [4:0] cursor_row;

    modport master (
        output in_valid, in_data,
        input  in_ready, v_ada, v_din, v_cea, busy, cursor_col, cursor_row
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, v_ada, v_din, v_cea, busy, cursor_col, cursor_row
    );
endinterface

// File: rtl/vram_text_writer.sv
// ---------------------------------------------------------------------------
// vram_text_writer
// Write-side terminal engine for the text VRAM. Consumes a valid/ready byte
// stream and writes character codes into VRAM port A on a 60x17 grid
// (row-major, address row*COLS+col). Handles LF, CR, FF, BS, auto-wrap and
// a full-screen clear after reset.
//
// Ports:
//   clk  : memory clock, all logic on the rising edge
//   rst  : asynchronous active-high reset (restarts the full clear)
//   bus  : vram_text_writer_if.slave
//          in_valid/in_data/in_ready - byte stream handshake
//          v_ada/v_din/v_cea         - VRAM port-A write (one cell per strobe)
//          busy                      - high whenever not idle
//          cursor_col/cursor_row     - current cursor position
//
// Configuration macro: VRAM_WRITER_LINE_CLEAR_EN
//   defined   : every row advance clears the new row (CLR_LINE state)
//   undefined : row advance only moves the cursor
// ---------------------------------------------------------------------------
module vram_text_writer #(
    parameter int unsigned COLS       = 60,
    parameter int unsigned ROWS       = 17,
    parameter int unsigned VRAM_DEPTH = 1024,
    parameter logic [7:0]  FILL_CHAR  = 8'h20
) (
    input  logic                clk,
    input  logic                rst,
    vram_text_writer_if.slave   bus
);

    localparam logic [5:0]  LAST_COL = 6'(COLS - 1);
    localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);
    localparam logic [10:0] CLR_END  = 11'(VRAM_DEPTH);
    localparam logic [10:0] LINE_END = 11'(COLS);

    typedef enum logic [1:0] {
        ST_CLR_ALL  = 2'd0,
        ST_IDLE     = 2'd1,
        ST_WRITE    = 2'd2
`ifdef VRAM_WRITER_LINE_CLEAR_EN
        ,ST_CLR_LINE = 2'd3
`endif
    } state_e;

    state_e      state_q;
    logic [10:0] clr_addr_q;   // full-screen address, or column within a line clear
    logic [5:0]  col_q;
    logic [4:0]  row_q;
    logic        in_ready_q;
    logic        busy_q;
    logic        v_cea_q;
    logic [9:0]  v_ada_q;
    logic [7:0]  v_din_q;
`ifdef VRAM_WRITER_LINE_CLEAR_EN
    logic        clr_pend_q;   // auto-wrap during a write: clear the new row afterwards
`endif

    // row*60+col as (row<<6)-(row<<2)+col; modulo-1024 arithmetic keeps it exact
    function automatic logic [9:0] cell_addr(input logic [4:0] r, input logic [5:0] c);
        return {r[3:0], 6'b000000} - {3'b000, r, 2'b00} + {4'b0000, c};
    endfunction

    // Row advance wraps to the top with no scrolling
    function automatic logic [4:0] next_row(input logic [4:0] r);
        return (r == LAST_ROW) ? 5'd0 : r + 5'd1;
    endfunction

    // Control FSM with registered VRAM strobe, handshake and cursor
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_CLR_ALL;
            clr_addr_q <= 11'd0;
            col_q      <= 6'd0;
            row_q      <= 5'd0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            v_cea_q    <= 1'b0;
            v_ada_q    <= 10'd0;
            v_din_q    <= 8'h00;
`ifdef VRAM_WRITER_LINE_CLEAR_EN
            clr_pend_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_CLR_ALL: begin
                    col_q <= 6'd0;
                    row_q <= 5'd0;
                    if (clr_addr_q == CLR_END) begin
                        state_q    <= ST_IDLE;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        v_cea_q    <= 1'b0;
                    end else begin
                        v_cea_q    <= 1'b1;
                        v_ada_q    <= clr_addr_q[9:0];
                        v_din_q    <= FILL_CHAR;
                        clr_addr_q <= clr_addr_q + 11'd1;
                    end
                end

                ST_IDLE: begin
                    v_cea_q <= 1'b0;
                    if (bus.in_valid) begin
                        if (bus.in_data == 8'h0C) begin
                            col_q      <= 6'd0;
                            row_q      <= 5'd0;
                            clr_addr_q <= 11'd0;
                            state_q    <= ST_CLR_ALL;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                        end else if (bus.in_data == 8'h0A) begin
                            col_q <= 6'd0;
                            row_q <= next_row(row_q);
`ifdef VRAM_WRITER_LINE_CLEAR_EN
                            clr_addr_q <= 11'd0;
                            state_q    <= ST_CLR_LINE;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
`endif
                        end else if (bus.in_data == 8'h0D) begin
                            col_q <= 6'd0;
                        end else if (bus.in_data == 8'h08) begin
                            // Backspace at column 0 is a no-op
                            if (col_q != 6'd0) begin
                                col_q      <= col_q - 6'd1;
                                v_cea_q    <= 1'b1;
                                v_ada_q    <= cell_addr(row_q, col_q - 6'd1);
                                v_din_q    <= FILL_CHAR;
                                state_q    <= ST_WRITE;
                                in_ready_q <= 1'b0;
                                busy_q     <= 1'b1;
                            end else begin
                                col_q <= col_q;
                            end
                        end else if (bus.in_data >= 8'h09 && bus.in_data <= 8'h1F) begin
                            // Unsupported control code: consumed and dropped
                            col_q <= col_q;
                        end else begin
                            v_cea_q    <= 1'b1;
                            v_ada_q    <= cell_addr(row_q, col_q);
                            v_din_q    <= bus.in_data;
                            state_q    <= ST_WRITE;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                            if (col_q == LAST_COL) begin
                                col_q <= 6'd0;
                                row_q <= next_row(row_q);
`ifdef VRAM_WRITER_LINE_CLEAR_EN
                                clr_pend_q <= 1'b1;
`endif
                            end else begin
                                col_q <= col_q + 6'd1;
                            end
                        end
                    end else begin
                        col_q <= col_q;
                    end
                end

                ST_WRITE: begin
                    v_cea_q <= 1'b0;
`ifdef VRAM_WRITER_LINE_CLEAR_EN
                    if (clr_pend_q) begin
                        clr_pend_q <= 1'b0;
                        clr_addr_q <= 11'd0;
                        state_q    <= ST_CLR_LINE;
                    end else begin
                        state_q    <= ST_IDLE;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end
`else
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
`endif
                end

`ifdef VRAM_WRITER_LINE_CLEAR_EN
                ST_CLR_LINE: begin
                    if (clr_addr_q == LINE_END) begin
                        state_q    <= ST_IDLE;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        v_cea_q    <= 1'b0;
                    end else begin
                        v_cea_q    <= 1'b1;
                        v_ada_q    <= cell_addr(row_q, clr_addr_q[5:0]);
                        v_din_q    <= FILL_CHAR;
                        clr_addr_q <= clr_addr_q + 11'd1;
                    end
                end
`endif

                default: begin
                    state_q    <= ST_CLR_ALL;
                    clr_addr_q <= 11'd0;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b1;
                    v_cea_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.busy       = busy_q;
    assign bus.v_cea      = v_cea_q;
    assign bus.v_ada      = v_ada_q;
    assign bus.v_din      = v_din_q;
    assign bus.cursor_col = col_q;
    assign bus.cursor_row = row_q;

endmodule

// File: tb/tb_vram_text_writer.sv
module tb_vram_text_writer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    vram_text_writer_if bus ();

    vram_text_writer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Observed VRAM writes {addr, data}
    logic [17:0] wr_q[$];
    // Expected VRAM writes from the reference model
    logic [17:0] exp_q[$];
    int m_col = 0;
    int m_row = 0;

    always @(negedge clk) begin
        if (!rst && bus.v_cea === 1'b1) wr_q.push_back({bus.v_ada, bus.v_din});
    end

    function automatic logic [9:0] m_addr(input int r, input int c);
        return 10'(r * 60 + c);
    endfunction

    // Index of first disagreement between observed and expected writes, -1 if none
    function automatic int first_diff();
        int n;
        n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (wr_q[i] !== exp_q[i]) return i;
        if (wr_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    // Row advance of the terminal: wrap to the top, optionally blank the new row
    task automatic model_advance();
        m_row = (m_row + 1) % 17;
`ifdef VRAM_WRITER_LINE_CLEAR_EN
        for (int c = 0; c < 60; c++) exp_q.push_back({m_addr(m_row, c), 8'h20});
`endif
    endtask

    // Terminal behaviour for one accepted byte
    task automatic model_byte(input logic [7:0] b);
        if (b == 8'h0C) begin
            m_col = 0;
            m_row = 0;
            for (int i = 0; i < 1024; i++) exp_q.push_back({10'(i), 8'h20});
        end else if (b == 8'h0A) begin
            m_col = 0;
            model_advance();
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col = m_col - 1;
                exp_q.push_back({m_addr(m_row, m_col), 8'h20});
            end
        end else if (b >= 8'h09 && b <= 8'h1F) begin
            m_col = m_col;
        end else begin
            exp_q.push_back({m_addr(m_row, m_col), b});
            m_col = m_col + 1;
            if (m_col == 60) begin
                m_col = 0;
                model_advance();
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            errors++;
            checks++;
            $display("FAIL send_timeout byte=%02h in_ready never rose", b);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy !== 1'b0) begin
            errors++;
            checks++;
            $display("FAIL idle_timeout busy still %b", bus.busy);
        end
    endtask

    task automatic model_send(input logic [7:0] b);
        model_byte(b);
        send_byte(b);
        wait_idle();
    endtask

    task automatic clear_logs();
        wr_q.delete();
        exp_q.delete();
    endtask

    // Walks through one full-screen clear from the cycle before its first strobe
    task automatic observe_full_clear(output int bad, output bit tail_ok);
        int n = 0;
        bad = 0;
        while (bus.v_cea !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 1024; i++) begin
            if (!(bus.v_cea === 1'b1 && bus.v_ada === 10'(i) && bus.v_din === 8'h20)) bad++;
            @(negedge clk);
        end
        tail_ok = (bus.v_cea === 1'b0 && bus.in_ready === 1'b1 && bus.busy === 1'b0);
    endtask

    task automatic test_reset();
        int bad;
        bit tail_ok;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.busy, bus.v_cea, bus.v_ada, bus.v_din, bus.cursor_col, bus.cursor_row}
            !== {1'b0, 1'b1, 1'b0, 10'd0, 8'd0, 6'd0, 5'd0}) begin
            errors++;
            $display("FAIL reset_values rdy=%b busy=%b cea=%b ada=%h din=%h col=%0d row=%0d expected 0 1 0 0 0 0 0",
                     bus.in_ready, bus.busy, bus.v_cea, bus.v_ada, bus.v_din, bus.cursor_col, bus.cursor_row);
        end
        rst = 1'b0;
        observe_full_clear(bad, tail_ok);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL boot_clear_seq bad_cycles=%0d expected 0", bad);
        end
        checks++;
        if (tail_ok !== 1'b1) begin
            errors++;
            $display("FAIL boot_clear_tail cea=%b rdy=%b busy=%b expected 0 1 0", bus.v_cea, bus.in_ready, bus.busy);
        end
        m_col = 0;
        m_row = 0;
        clear_logs();
    endtask

    task automatic test_chars_ab();
        logic [7:0] ch[2] = '{8'h41, 8'h42};
        clear_logs();
        for (int k = 0; k < 2; k++) begin
            model_byte(ch[k]);
            send_byte(ch[k]);
            checks++;
            if ({bus.in_ready, bus.v_cea, bus.v_ada, bus.v_din} !== {1'b0, 1'b1, 10'(k), ch[k]}) begin
                errors++;
                $display("FAIL ab_write_cycle rdy=%b cea=%b ada=%h din=%h expected 0 1 %h %h",
                         bus.in_ready, bus.v_cea, bus.v_ada, bus.v_din, 10'(k), ch[k]);
            end
            @(negedge clk);
            checks++;
            if ({bus.in_ready, bus.v_cea} !== 2'b10) begin
                errors++;
                $display("FAIL ab_ready_back rdy=%b cea=%b expected 1 0", bus.in_ready, bus.v_cea);
            end
        end
        checks++;
        if (first_diff() != -1) begin
            errors++;
            $display("FAIL ab_writes got=%0d entries expected=%0d diff_at=%0d", wr_q.size(), exp_q.size(), first_diff());
        end
        checks++;
        if ({bus.cursor_col, bus.cursor_row} !== {6'd2, 5'd0}) begin
            errors++;
            $display("FAIL ab_cursor col=%0d row=%0d expected 2 0", bus.cursor_col, bus.cursor_row);
        end
    endtask

    task automatic test_autowrap();
        clear_logs();
        model_send(8'h0C);
        checks++;
        if (first_diff() != -1) begin
            errors++;
            $display("FAIL ff_clear got=%0d entries expected=%0d diff_at=%0d", wr_q.size(), exp_q.size(), first_diff());
        end
        clear_logs();
        for (int i = 0; i < 60; i++) model_send(8'h78);
        model_send(8'h79);
        checks++;
        if (wr_q.size() == 0 || wr_q[$] !== {10'h03C, 8'h79}) begin
            errors++;
            $display("FAIL wrap_y_write last=%h expected %h", (wr_q.size() == 0) ? 18'h0 : wr_q[$], {10'h03C, 8'h79});
        end
        checks++;
        if (first_diff() != -1) begin
            errors++;
            $display("FAIL wrap_writes got=%0d entries expected=%0d diff_at=%0d", wr_q.size(), exp_q.size(), first_diff());
        end
        checks++;
        if ({bus.cursor_col, bus.cursor_row} !== {6'd1, 5'd1}) begin
            errors++;
            $display("FAIL wrap_cursor col=%0d row=%0d expected 1 1", bus.cursor_col, bus.cursor_row);
        end
    endtask

    task automatic test_lf_wrap();
        int exp_n;
        clear_logs();
        model_send(8'h0C);
        for (int i = 0; i < 16; i++) model_send(8'h0A);
        for (int i = 0; i < 5; i++) model_send(8'h63);
        checks++;
        if ({bus.cursor_col, bus.cursor_row} !== {6'd5, 5'd16}) begin
            errors++;
            $display("FAIL lf_setup_cursor col=%0d row=%0d expected 5 16", bus.cursor_col, bus.cursor_row);
        end
        clear_logs();
        model_send(8'h0A);
`ifdef VRAM_WRITER_LINE_CLEAR_EN
        exp_n = 60;
`else
        exp_n = 0;
`endif
        checks++;
        if (wr_q.size() != exp_n) begin
            errors++;
            $display("FAIL lf_wrap_count got=%0d expected=%0d", wr_q.size(), exp_n);
        end
        checks++;
        if (first_diff() != -1) begin
            errors++;
            $display("FAIL lf_wrap_writes got=%0d entries expected=%0d diff_at=%0d", wr_q.size(), exp_q.size(), first_diff());
        end
        checks++;
        if ({bus.cursor_col, bus.cursor_row} !== {6'd0, 5'd0}) begin
            errors++;
            $display("FAIL lf_wrap_cursor col=%0d row=%0d expected 0 0", bus.cursor_col, bus.cursor_row);
        end
    endtask

    task automatic test_backspace();
        model_send(8'h0C);
        for (int i = 0; i < 3; i++) model_send(8'h0A);
        clear_logs();
        model_send(8'h08);
        checks++;
        if (wr_q.size() != 0 || {bus.cursor_col, bus.cursor_row} !== {6'd0, 5'd3}) begin
            errors++;
            $display("FAIL bs_col0 writes=%0d col=%0d row=%0d expected 0 0 3", wr_q.size(), bus.cursor_col, bus.cursor_row);
        end
        model_send(8'h51);
        model_send(8'h08);
        checks++;
        if (wr_q.size() != 2 || wr_q[0] !== {10'h0B4, 8'h51} || wr_q[1] !== {10'h0B4, 8'h20}) begin
            errors++;
            $display("FAIL bs_writes count=%0d expected (0b4,51),(0b4,20)", wr_q.size());
        end
        checks++;
        if ({bus.cursor_col, bus.cursor_row} !== {6'd0, 5'd3}) begin
            errors++;
            $display("FAIL bs_cursor col=%0d row=%0d expected 0 3", bus.cursor_col, bus.cursor_row);
        end
    endtask

    task automatic test_busy_hold();
        int rdy_seen = 0;
        clear_logs();
        model_byte(8'h0C);
        model_byte(8'h5A);
        send_byte(8'h0C);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        for (int i = 0; i < 100; i++) begin
            if (bus.in_ready === 1'b1) rdy_seen++;
            @(negedge clk);
        end
        checks++;
        if (rdy_seen != 0) begin
            errors++;
            $display("FAIL hold_ready_while_busy ready_cycles=%0d expected 0", rdy_seen);
        end
        send_byte(8'h5A);
        wait_idle();
        checks++;
        if (first_diff() != -1) begin
            errors++;
            $display("FAIL hold_writes got=%0d entries expected=%0d diff_at=%0d", wr_q.size(), exp_q.size(), first_diff());
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int sel;
        for (int k = 0; k < 150; k++) begin
            clear_logs();
            sel = $urandom_range(0, 99);
            if (sel < 50)      b = 8'($urandom_range(32, 255));
            else if (sel < 60) b = 8'h0A;
            else if (sel < 68) b = 8'h08;
            else if (sel < 73) b = 8'h0D;
            else if (sel < 75) b = 8'h0C;
            else if (sel < 88) b = 8'($urandom_range(9, 31));
            else               b = 8'($urandom_range(0, 7));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            model_send(b);
            checks++;
            if (first_diff() != -1) begin
                errors++;
                $display("FAIL rand_writes byte=%02h got=%0d expected=%0d diff_at=%0d", b, wr_q.size(), exp_q.size(), first_diff());
            end
            checks++;
            if (bus.cursor_col !== 6'(m_col) || bus.cursor_row !== 5'(m_row)) begin
                errors++;
                $display("FAIL rand_cursor byte=%02h col=%0d row=%0d expected %0d %0d", b, bus.cursor_col, bus.cursor_row, m_col, m_row);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int n = 0;
        int bad;
        bit tail_ok;
        send_byte(8'h0C);
        while (!(bus.v_cea === 1'b1 && bus.v_ada === 10'd500) && n < 1100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(bus.v_cea === 1'b1 && bus.v_ada === 10'd500)) begin
            errors++;
            $display("FAIL midclr_reach ada=%h expected 1f4", bus.v_ada);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.in_ready, bus.busy, bus.v_cea, bus.v_ada, bus.v_din, bus.cursor_col, bus.cursor_row}
            !== {1'b0, 1'b1, 1'b0, 10'd0, 8'd0, 6'd0, 5'd0}) begin
            errors++;
            $display("FAIL midclr_reset_values rdy=%b busy=%b cea=%b ada=%h din=%h expected 0 1 0 0 0",
                     bus.in_ready, bus.busy, bus.v_cea, bus.v_ada, bus.v_din);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        observe_full_clear(bad, tail_ok);
        checks++;
        if (bad !== 0 || tail_ok !== 1'b1) begin
            errors++;
            $display("FAIL midclr_restart bad_cycles=%0d tail_ok=%b expected 0 1", bad, tail_ok);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        test_reset();
        test_chars_ab();
        test_autowrap();
        test_lf_wrap();
        test_backspace();
        test_busy_hold();
        test_random();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
